cam_learn_ctrl: RTL and testbench

Request sequencer upstream of the 16x8 content-addressable memory. It accepts 8-bit keys over a valid/ready handshake, runs a CAM search, and on a miss writes the key into the next free or oldest entry. It returns the entry index with hit, new and error flags. It also owns CAM initialisation, since the CAM has no reset and no valid bits.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_learn_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cam_learn_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the CAM learn controller and its wrapper.
package cam_pkg;

    localparam int KEY_W = 8;
    localparam int IDX_W = 4;
    localparam int DEPTH = 16;

    // Sentinel written to every entry at init; a request carrying it is rejected.
    localparam logic [KEY_W-1:0] INIT_KEY = 8'hFF;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SEARCH,
        CHECK,
        WRITE,
        RESP
    } state_e;

endpackage

// File: rtl/cam_learn_ctrl.sv
// Search-then-learn sequencer in front of a 16x8 CAM; also initialises the CAM after reset.
// Optional FIFO eviction on a full table is enabled by defining CAM_LEARN_EVICT_EN.
module cam_learn_ctrl
    import cam_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [KEY_W-1:0] req_key,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_index,
    output logic             resp_hit,
    output logic             resp_new,
    output logic             resp_err,
    output logic [IDX_W:0]   used,
    output logic             cam_wen,
    output logic             cam_ren,
    output logic [KEY_W-1:0] cam_din,
    output logic [IDX_W-1:0] cam_addr,
    input  logic [IDX_W-1:0] cam_dout,
    input  logic             cam_hit
);

`ifdef CAM_LEARN_EVICT_EN
    localparam bit EVICT_EN = 1'b1;
`else
    localparam bit EVICT_EN = 1'b0;
`endif

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    state_e           state_q, state_d;
    logic [IDX_W:0]   init_cnt_q, init_cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [IDX_W-1:0] alloc_q, alloc_d;
    logic [IDX_W:0]   used_q, used_d;

    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0] resp_index_q, resp_index_d;
    logic             resp_hit_q, resp_hit_d;
    logic             resp_new_q, resp_new_d;
    logic             resp_err_q, resp_err_d;
    logic             cam_wen_q, cam_wen_d;
    logic             cam_ren_q, cam_ren_d;
    logic [KEY_W-1:0] cam_din_q, cam_din_d;
    logic [IDX_W-1:0] cam_addr_q, cam_addr_d;

    // All outputs are registered: the _d values describe what the next state drives.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        key_d        = key_q;
        alloc_d      = alloc_q;
        used_d       = used_q;
        req_ready_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_index_d = resp_index_q;
        resp_hit_d   = resp_hit_q;
        resp_new_d   = resp_new_q;
        resp_err_d   = resp_err_q;
        cam_wen_d    = 1'b0;
        cam_ren_d    = 1'b0;
        cam_din_d    = '0;
        cam_addr_d   = '0;

        case (state_q)
            INIT: begin
                if (init_cnt_q == FULL) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    cam_wen_d  = 1'b1;
                    cam_din_d  = INIT_KEY;
                    cam_addr_d = init_cnt_q[IDX_W-1:0];
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    key_d = req_key;
                    if (req_key == INIT_KEY) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_index_d = '0;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d   = SEARCH;
                        cam_ren_d = 1'b1;
                        cam_din_d = req_key;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            SEARCH: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (cam_hit) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_index_d = cam_dout;
                    resp_hit_d   = 1'b1;
                end else if (used_q != FULL || EVICT_EN) begin
                    state_d    = WRITE;
                    cam_wen_d  = 1'b1;
                    cam_addr_d = alloc_q;
                    cam_din_d  = key_q;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_index_d = '0;
                    resp_err_d   = 1'b1;
                end
            end
            WRITE: begin
                // alloc_q wraps naturally, so a full table overwrites the oldest entry.
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_index_d = alloc_q;
                resp_new_d   = 1'b1;
                alloc_d      = alloc_q + 1'b1;
                if (used_q != FULL) begin
                    used_d = used_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_index_d = '0;
                    resp_hit_d   = 1'b0;
                    resp_new_d   = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            key_q        <= '0;
            alloc_q      <= '0;
            used_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_index_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_new_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            cam_wen_q    <= 1'b0;
            cam_ren_q    <= 1'b0;
            cam_din_q    <= '0;
            cam_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            key_q        <= key_d;
            alloc_q      <= alloc_d;
            used_q       <= used_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_index_q <= resp_index_d;
            resp_hit_q   <= resp_hit_d;
            resp_new_q   <= resp_new_d;
            resp_err_q   <= resp_err_d;
            cam_wen_q    <= cam_wen_d;
            cam_ren_q    <= cam_ren_d;
            cam_din_q    <= cam_din_d;
            cam_addr_q   <= cam_addr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_index = resp_index_q;
    assign resp_hit   = resp_hit_q;
    assign resp_new   = resp_new_q;
    assign resp_err   = resp_err_q;
    assign used       = used_q;
    assign cam_wen    = cam_wen_q;
    assign cam_ren    = cam_ren_q;
    assign cam_din    = cam_din_q;
    assign cam_addr   = cam_addr_q;

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Directed bench for cam_learn_ctrl with a behavioural 16x8 CAM attached to the cam_* ports.
module tb_cam_learn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_key = 8'h00;
    logic       resp_ready = 1'b0;
    logic       req_ready, resp_valid, resp_hit, resp_new, resp_err;
    logic [3:0] resp_index;
    logic [4:0] used;
    logic       cam_wen, cam_ren;
    logic [7:0] cam_din;
    logic [3:0] cam_addr;
    logic [3:0] cam_dout = 4'h0;
    logic       cam_hit = 1'b0;

    int tot = 0;
    int pass = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;
    int both_cnt = 0;

    cam_learn_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_index(resp_index),
        .resp_hit(resp_hit), .resp_new(resp_new), .resp_err(resp_err), .used(used),
        .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din), .cam_addr(cam_addr),
        .cam_dout(cam_dout), .cam_hit(cam_hit)
    );

    always #5 clk = ~clk;

    // CAM has no reset: power-up contents collide with the first test key.
    logic [7:0] mem [16] = '{default: 8'h3C};
    logic       hit_v;
    logic [3:0] idx_v;

    always @(posedge clk) begin
        if (cam_ren) begin
            hit_v = 1'b0;
            idx_v = 4'h0;
            for (int i = 15; i >= 0; i--) begin
                if (mem[i] == cam_din) begin
                    hit_v = 1'b1;
                    idx_v = 4'(i);
                end
            end
            cam_hit  <= hit_v;
            cam_dout <= idx_v;
        end
        if (cam_wen) mem[cam_addr] <= cam_din;
        if (cam_wen) wen_cnt <= wen_cnt + 1;
        if (cam_ren) ren_cnt <= ren_cnt + 1;
        if (cam_wen && cam_ren) both_cnt <= both_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 60) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            tot++;
            $display("FAIL %s: req_ready timeout, got %b want 1", tag, req_ready);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_ready("do_reset");
    endtask

    // lat counts cycles from the accept edge (edge 0) to the first cycle showing resp_valid.
    task automatic send_req(input logic [7:0] k, output int lat);
        req_valid = 1'b1;
        req_key   = k;
        wait_ready("send_req");
        tick();
        req_valid = 1'b0;
        req_key   = 8'h00;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        int bad_i = -1;
        rst = 1'b1;
        tick();
        tick();
        tot++;
        if ({req_ready, resp_valid, resp_hit, resp_new, resp_err, cam_wen, cam_ren} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000",
                     {req_ready, resp_valid, resp_hit, resp_new, resp_err, cam_wen, cam_ren});
        else pass++;
        tot++;
        if ({used, resp_index, cam_din, cam_addr} !== 21'h0)
            $display("FAIL reset_values: used=%0d idx=%0d din=%h addr=%0d want all 0",
                     used, resp_index, cam_din, cam_addr);
        else pass++;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (cam_wen !== 1'b1 || cam_ren !== 1'b0 || cam_din !== 8'hFF ||
                cam_addr !== 4'(i) || req_ready !== 1'b0) begin
                if (bad == 0) bad_i = i;
                bad++;
            end
        end
        tot++;
        if (bad != 0)
            $display("FAIL init_seq: %0d bad cycles, first at %0d (wen=%b ren=%b din=%h addr=%0d), want wen=1 din=ff addr=cycle",
                     bad, bad_i, cam_wen, cam_ren, cam_din, cam_addr);
        else pass++;
        tick();
        tot++;
        if (req_ready !== 1'b1 || cam_wen !== 1'b0)
            $display("FAIL init_ready: req_ready=%b cam_wen=%b want 1/0", req_ready, cam_wen);
        else pass++;
        tot++;
        if (used !== 5'd0) $display("FAIL init_used: got %0d want 0", used);
        else pass++;
    endtask

    task automatic test_learn_hit();
        int lat;
        send_req(8'h3C, lat);
        tot++;
        if (lat != 4 || resp_index !== 4'd0 || {resp_hit, resp_new, resp_err} !== 3'b010)
            $display("FAIL learn_3c: lat=%0d idx=%0d hne=%b want lat=4 idx=0 hne=010",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
        tot++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL after_ack: req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid);
        else pass++;
        tot++;
        if (used !== 5'd1) $display("FAIL used_1: got %0d want 1", used);
        else pass++;
        send_req(8'h3C, lat);
        tot++;
        if (lat != 3 || resp_index !== 4'd0 || {resp_hit, resp_new, resp_err} !== 3'b100)
            $display("FAIL hit_3c: lat=%0d idx=%0d hne=%b want lat=3 idx=0 hne=100",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
        tot++;
        if (used !== 5'd1) $display("FAIL used_after_hit: got %0d want 1", used);
        else pass++;
    endtask

    task automatic test_reserved();
        int lat;
        int w = wen_cnt;
        int r = ren_cnt;
        send_req(8'hFF, lat);
        tot++;
        if (lat != 1 || resp_index !== 4'd0 || {resp_hit, resp_new, resp_err} !== 3'b001)
            $display("FAIL reserved: lat=%0d idx=%0d hne=%b want lat=1 idx=0 hne=001",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
        tot++;
        if (wen_cnt != w || ren_cnt != r)
            $display("FAIL reserved_no_cam: wen+%0d ren+%0d want 0/0", wen_cnt - w, ren_cnt - r);
        else pass++;
    endtask

    task automatic test_full();
        int lat;
        int bad = 0;
        int w;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_req(8'(i), lat);
            if (lat != 4 || resp_index !== 4'(i) || {resp_hit, resp_new, resp_err} !== 3'b010)
                bad++;
            ack();
        end
        tot++;
        if (bad != 0) $display("FAIL fill_table: %0d bad responses want 0", bad);
        else pass++;
        tot++;
        if (used !== 5'd16) $display("FAIL used_full: got %0d want 16", used);
        else pass++;
        w = wen_cnt;
        send_req(8'h20, lat);
`ifdef CAM_LEARN_EVICT_EN
        tot++;
        if (lat != 4 || resp_index !== 4'd0 || {resp_hit, resp_new, resp_err} !== 3'b010)
            $display("FAIL evict_20: lat=%0d idx=%0d hne=%b want lat=4 idx=0 hne=010",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
        send_req(8'h00, lat);
        tot++;
        if (lat != 4 || resp_index !== 4'd1 || {resp_hit, resp_new, resp_err} !== 3'b010)
            $display("FAIL evicted_00: lat=%0d idx=%0d hne=%b want lat=4 idx=1 hne=010",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
`else
        tot++;
        if (lat != 3 || resp_index !== 4'd0 || {resp_hit, resp_new, resp_err} !== 3'b001)
            $display("FAIL full_20: lat=%0d idx=%0d hne=%b want lat=3 idx=0 hne=001",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
        tot++;
        if (wen_cnt != w) $display("FAIL full_no_write: wen+%0d want 0", wen_cnt - w);
        else pass++;
`endif
        tot++;
        if (used !== 5'd16) $display("FAIL used_stays_16: got %0d want 16", used);
        else pass++;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        send_req(8'h05, lat);
        tot++;
        if (lat != 3 || resp_index !== 4'd5 || {resp_hit, resp_new, resp_err} !== 3'b100)
            $display("FAIL bp_hit: lat=%0d idx=%0d hne=%b want lat=3 idx=5 hne=100",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_index !== 4'd5 || req_ready !== 1'b0 ||
                {resp_hit, resp_new, resp_err} !== 3'b100)
                bad++;
        end
        tot++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        else pass++;
        ack();
        tot++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL bp_release: resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        else pass++;
    endtask

    task automatic test_rst_write();
        int lat;
        do_reset();
        send_req(8'h11, lat);
        ack();
        req_valid = 1'b1;
        req_key   = 8'h77;
        wait_ready("rst_write");
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tot++;
        if (cam_wen !== 1'b1 || cam_addr !== 4'd1)
            $display("FAIL write_cycle: wen=%b addr=%0d want 1/1", cam_wen, cam_addr);
        else pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tot++;
        if (resp_valid !== 1'b0 || used !== 5'd0 || cam_wen !== 1'b0)
            $display("FAIL mid_reset: resp_valid=%b used=%0d wen=%b want 0/0/0",
                     resp_valid, used, cam_wen);
        else pass++;
        tick();
        tot++;
        if (cam_wen !== 1'b1 || cam_addr !== 4'd0 || cam_din !== 8'hFF)
            $display("FAIL reinit_start: wen=%b addr=%0d din=%h want 1/0/ff", cam_wen, cam_addr, cam_din);
        else pass++;
        wait_ready("reinit");
        send_req(8'h11, lat);
        tot++;
        if (lat != 4 || resp_index !== 4'd0 || {resp_hit, resp_new, resp_err} !== 3'b010)
            $display("FAIL relearn_11: lat=%0d idx=%0d hne=%b want lat=4 idx=0 hne=010",
                     lat, resp_index, {resp_hit, resp_new, resp_err});
        else pass++;
        ack();
        tot++;
        if (used !== 5'd1) $display("FAIL used_after_reinit: got %0d want 1", used);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_learn_hit();
        test_reserved();
        test_full();
        test_backpressure();
        test_rst_write();
        tot++;
        if (both_cnt != 0) $display("FAIL wen_ren_overlap: got %0d cycles want 0", both_cnt);
        else pass++;
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
